// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and pattern generator on a single clock, with a
// clock-enable prescaler setting the pixel rate.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int COLOR_W   = 4
) (
  input  logic               clock50MHz,
  input  logic               inReset,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] inRed,
  input  logic [COLOR_W-1:0] inGreen,
  input  logic [COLOR_W-1:0] inBlue,
  output logic               hSync,
  output logic               vSync,
  output logic [COLOR_W-1:0] outRed,
  output logic [COLOR_W-1:0] outGreen,
  output logic [COLOR_W-1:0] outBlue,
  output logic [10:0]        pixelX,
  output logic [10:0]        pixelY,
  output logic               displayEnable,
  output logic               pixelTick,
  output logic               frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] BAR_DIV  = 11'(BAR_W);
  localparam logic HPOL = 1'(HSYNC_POL);
  localparam logic VPOL = 1'(VSYNC_POL);
  localparam logic [COLOR_W-1:0] FULL = '1;

  logic [DIV_W-1:0]   divCnt;
  logic [10:0]        hCnt, vCnt;
  logic [1:0]         activeMode;
  logic               tick, hWrap, vWrap, active, hsAct, vsAct;
  logic [10:0]        barQ;
  logic [2:0]         barIdx;
  logic [COLOR_W-1:0] nxtRed, nxtGreen, nxtBlue;

  assign tick   = (divCnt == DIV_LAST);
  assign hWrap  = (hCnt == H_LAST);
  assign vWrap  = (vCnt == V_LAST);
  assign active = (hCnt < H_ACT) && (vCnt < V_ACT);
  assign hsAct  = (hCnt >= HS_START) && (hCnt <= HS_END);
  assign vsAct  = (vCnt >= VS_START) && (vCnt <= VS_END);

  // Bar index saturates at 7 so the division remainder widens the last bar.
  always_comb begin
    nxtRed   = '0;
    nxtGreen = '0;
    nxtBlue  = '0;
    barQ     = hCnt / BAR_DIV;
    barIdx   = (barQ > 11'd7) ? 3'd7 : barQ[2:0];
    if (active) begin
      case (activeMode)
        2'b01: begin
          nxtRed   = barIdx[1] ? '0 : FULL;
          nxtGreen = barIdx[2] ? '0 : FULL;
          nxtBlue  = barIdx[0] ? '0 : FULL;
        end
        2'b10: begin
          if (!(hCnt[5] ^ vCnt[5])) begin
            nxtRed   = FULL;
            nxtGreen = FULL;
            nxtBlue  = FULL;
          end
        end
        default: begin
          nxtRed   = inRed;
          nxtGreen = inGreen;
          nxtBlue  = inBlue;
        end
      endcase
    end
  end

  always_ff @(posedge clock50MHz) begin
    if (!inReset) begin
      divCnt        <= '0;
      hCnt          <= '0;
      vCnt          <= '0;
      activeMode    <= 2'b00;
      hSync         <= ~HPOL;
      vSync         <= ~VPOL;
      outRed        <= '0;
      outGreen      <= '0;
      outBlue       <= '0;
      pixelX        <= '0;
      pixelY        <= '0;
      displayEnable <= 1'b0;
      pixelTick     <= 1'b0;
      frameStart    <= 1'b0;
    end else begin
      pixelTick <= tick;
      divCnt    <= tick ? '0 : divCnt + DIV_W'(1);
      if (tick) begin
        hCnt <= hWrap ? '0 : hCnt + 11'd1;
        if (hWrap) vCnt <= vWrap ? '0 : vCnt + 11'd1;
        // Mode only changes across a frame boundary so a frame never tears.
        if (hWrap && vWrap) activeMode <= mode;
        hSync         <= hsAct ? HPOL : ~HPOL;
        vSync         <= vsAct ? VPOL : ~VPOL;
        outRed        <= nxtRed;
        outGreen      <= nxtGreen;
        outBlue       <= nxtBlue;
        pixelX        <= hCnt;
        pixelY        <= vCnt;
        displayEnable <= active;
        frameStart    <= (hCnt == 11'd0) && (vCnt == 11'd0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: defaults (A), tiny CLK_DIV=1 line (B),
// and a reduced mode so whole frames fit in a short run (C).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [3:0] inR, inG, inB;
  logic       rstA, rstB, rstC;
  logic [1:0] modeA, modeB, modeC;
  logic       hsA, vsA, deA, ptA, fsA, hsB, vsB, deB, ptB, fsB, hsC, vsC, deC, ptC, fsC;
  logic [3:0] rA, gA, bA, rB, gB, bB, rC, gC, bC;
  logic [10:0] xA, yA, xB, yB, xC, yC;

  vga_timing_gen dutA (
    .clock50MHz(clk), .inReset(rstA), .mode(modeA),
    .inRed(inR), .inGreen(inG), .inBlue(inB),
    .hSync(hsA), .vSync(vsA), .outRed(rA), .outGreen(gA), .outBlue(bA),
    .pixelX(xA), .pixelY(yA), .displayEnable(deA), .pixelTick(ptA), .frameStart(fsA));

  vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .CLK_DIV(1), .HSYNC_POL(1)) dutB (
    .clock50MHz(clk), .inReset(rstB), .mode(modeB),
    .inRed(inR), .inGreen(inG), .inBlue(inB),
    .hSync(hsB), .vSync(vsB), .outRed(rB), .outGreen(gB), .outBlue(bB),
    .pixelX(xB), .pixelY(yB), .displayEnable(deB), .pixelTick(ptB), .frameStart(fsB));

  vga_timing_gen #(.H_ACTIVE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
                   .V_ACTIVE(40), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) dutC (
    .clock50MHz(clk), .inReset(rstC), .mode(modeC),
    .inRed(inR), .inGreen(inG), .inBlue(inB),
    .hSync(hsC), .vSync(vsC), .outRed(rC), .outGreen(gC), .outBlue(bC),
    .pixelX(xC), .pixelY(yC), .displayEnable(deC), .pixelTick(ptC), .frameStart(fsC));

  typedef struct {
    int         frame;
    int         x;
    int         y;
    logic [11:0] rgb;
    logic       de, hs, vs, fs;
    int         newMode;
  } vec_t;

  function automatic vec_t mk(input int f, input int x, input int y, input logic [11:0] rgb,
                              input logic de, input logic hs, input logic vs, input logic fs,
                              input int nm = -1);
    vec_t v;
    v.frame = f; v.x = x; v.y = y; v.rgb = rgb;
    v.de = de; v.hs = hs; v.vs = vs; v.fs = fs; v.newMode = nm;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic waitCyc(input int e);
    if (cyc > e) begin
      total++; bad++;
      $display("FAIL order target=%0d now=%0d", e, cyc);
    end
    while (cyc < e) @(negedge clk);
  endtask

  // Pixel n's outputs appear after edge rel + (div-1) + div*n and hold div clocks.
  task automatic checkVec(input int which, input int idx, input vec_t v, input int rel);
    int div, ht, vt, e, x, y;
    logic [11:0] rgb;
    logic de, hs, vs, fs, pt;
    bit ok;
    case (which)
      0: begin div = 2; ht = 800; vt = 525; end
      1: begin div = 1; ht = 12;  vt = 7;   end
      default: begin div = 2; ht = 80; vt = 46; end
    endcase
    e = rel + div - 1 + div * ((v.frame * vt + v.y) * ht + v.x);
    waitCyc(e);
    case (which)
      0: begin rgb = {rA, gA, bA}; de = deA; hs = hsA; vs = vsA; fs = fsA; pt = ptA; x = int'(xA); y = int'(yA); end
      1: begin rgb = {rB, gB, bB}; de = deB; hs = hsB; vs = vsB; fs = fsB; pt = ptB; x = int'(xB); y = int'(yB); end
      default: begin rgb = {rC, gC, bC}; de = deC; hs = hsC; vs = vsC; fs = fsC; pt = ptC; x = int'(xC); y = int'(yC); end
    endcase
    ok = (rgb == v.rgb) && (de == v.de) && (hs == v.hs) && (vs == v.vs) && (fs == v.fs) && pt &&
         (!v.de || (x == v.x && y == v.y));
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL vec dut%0d #%0d f%0d (%0d,%0d): got rgb=%h de=%b hs=%b vs=%b fs=%b pt=%b xy=%0d,%0d want rgb=%h de=%b hs=%b vs=%b fs=%b",
               which, idx, v.frame, v.x, v.y, rgb, de, hs, vs, fs, pt, x, y, v.rgb, v.de, v.hs, v.vs, v.fs);
    end
    if (v.newMode >= 0) begin
      case (which)
        0: modeA = 2'(v.newMode);
        1: modeB = 2'(v.newMode);
        default: modeC = 2'(v.newMode);
      endcase
    end
  endtask

  vec_t tblA[5];
  vec_t tblC[25];

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int relA, relB, relB2, relC, nF, nR, rise1, fallB, deCnt, vsLow;
    int fall[2];
    int riseB[2];
    logic prevHs;

    tblA[0] = mk(0,   0, 2, 12'h5A3, 1, 1, 1, 0);
    tblA[1] = mk(0, 639, 2, 12'h5A3, 1, 1, 1, 0);
    tblA[2] = mk(0, 640, 2, 12'h000, 0, 1, 1, 0);
    tblA[3] = mk(0, 700, 2, 12'h000, 0, 0, 1, 0);
    tblA[4] = mk(0, 799, 2, 12'h000, 0, 1, 1, 0);

    tblC[0]  = mk(0,  0,  0, 12'h5A3, 1, 1, 1, 1);
    tblC[1]  = mk(0,  3,  1, 12'h5A3, 1, 1, 1, 0);
    tblC[2]  = mk(0, 70, 42, 12'h000, 0, 0, 0, 0);
    tblC[3]  = mk(0, 76, 43, 12'h000, 0, 1, 0, 0);
    tblC[4]  = mk(0,  5, 44, 12'h000, 0, 1, 1, 0);
    tblC[5]  = mk(1,  0,  0, 12'hFFF, 1, 1, 1, 1);
    tblC[6]  = mk(1,  7,  0, 12'hFFF, 1, 1, 1, 0);
    tblC[7]  = mk(1,  8,  0, 12'hFF0, 1, 1, 1, 0);
    tblC[8]  = mk(1, 20,  5, 12'h0FF, 1, 1, 1, 0);
    tblC[9]  = mk(1, 35,  5, 12'hF0F, 1, 1, 1, 0);
    tblC[10] = mk(1, 47,  5, 12'hF00, 1, 1, 1, 0);
    tblC[11] = mk(1, 50,  6, 12'h00F, 1, 1, 1, 0);
    tblC[12] = mk(1, 63,  6, 12'h000, 1, 1, 1, 0);
    tblC[13] = mk(1, 64,  6, 12'h000, 0, 1, 1, 0);
    tblC[14] = mk(1, 10, 20, 12'hFF0, 1, 1, 1, 0, 2);
    tblC[15] = mk(1, 30, 20, 12'h0F0, 1, 1, 1, 0);
    tblC[16] = mk(1,  0, 21, 12'hFFF, 1, 1, 1, 0);
    tblC[17] = mk(1, 10, 41, 12'h000, 0, 1, 1, 0);
    tblC[18] = mk(2,  0,  0, 12'hFFF, 1, 1, 1, 1);
    tblC[19] = mk(2, 31,  0, 12'hFFF, 1, 1, 1, 0);
    tblC[20] = mk(2, 32,  0, 12'h000, 1, 1, 1, 0);
    tblC[21] = mk(2,  0, 32, 12'h000, 1, 1, 1, 0);
    tblC[22] = mk(2, 32, 32, 12'hFFF, 1, 1, 1, 0);
    tblC[23] = mk(2, 63, 39, 12'hFFF, 1, 1, 1, 0, 3);
    tblC[24] = mk(3,  9,  9, 12'h5A3, 1, 1, 1, 0);

    rstA = 0; rstB = 0; rstC = 0;
    modeA = 2'b00; modeB = 2'b00; modeC = 2'b01;
    inR = 4'h5; inG = 4'hA; inB = 4'h3;

    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("rstA_hs", hsA, 1);
    chk("rstA_vs", vsA, 1);
    chk("rstA_rgb", {rA, gA, bA}, 0);
    chk("rstA_de_pt_fs", {deA, ptA, fsA}, 0);
    chk("rstA_xy", {xA, yA}, 0);
    chk("rstB_hs", hsB, 0);
    chk("rstB_vs", vsB, 1);

    // Defaults: first tick latency, then one two-line window of sync timing.
    rstA = 1; relA = cyc + 1;
    waitCyc(relA);
    chk("A_preTick", {ptA, fsA}, 0);
    waitCyc(relA + 1);
    chk("A_firstTick", {ptA, fsA, deA}, 3'b111);
    waitCyc(relA + 2);
    chk("A_tickHold", {ptA, fsA}, 2'b01);
    waitCyc(relA + 3);
    chk("A_secondPix", {ptA, fsA, 1'b0, xA}, {2'b10, 12'd1});

    nF = 0; rise1 = 0; deCnt = 0; vsLow = 0; fall[0] = 0; fall[1] = 0;
    prevHs = hsA;
    while (cyc < relA + 3200) begin
      @(negedge clk);
      if (prevHs && !hsA && nF < 2) begin fall[nF] = cyc; nF++; end
      if (!prevHs && hsA && rise1 == 0) rise1 = cyc;
      if (cyc >= relA + 1600 && ptA && deA) deCnt++;
      if (!vsA) vsLow++;
      prevHs = hsA;
    end
    chk("A_hsFall", fall[0] - relA, 1313);
    chk("A_hsLow", rise1 - fall[0], 192);
    chk("A_hsPeriod", fall[1] - fall[0], 1600);
    chk("A_deTicks", deCnt, 640);
    chk("A_vsIdle", vsLow, 0);
    for (int i = 0; i < 5; i++) checkVec(0, i, tblA[i], relA);

    // Reduced mode: solid frame, bars frame, checkerboard frame, external.
    rstC = 1; relC = cyc + 1;
    for (int i = 0; i < 25; i++) checkVec(2, i, tblC[i], relC);

    // CLK_DIV=1 with active-high hSync, then a mid-line reset.
    rstB = 1; relB = cyc + 1;
    waitCyc(relB);
    chk("B_first", {ptB, fsB, deB, hsB}, 4'b1110);
    nR = 0; fallB = 0; riseB[0] = 0; riseB[1] = 0;
    prevHs = hsB;
    while (cyc < relB + 30) begin
      @(negedge clk);
      if (!prevHs && hsB && nR < 2) begin riseB[nR] = cyc; nR++; end
      if (prevHs && !hsB && fallB == 0) fallB = cyc;
      prevHs = hsB;
    end
    chk("B_hsRise", riseB[0] - relB, 9);
    chk("B_hsHigh", fallB - riseB[0], 2);
    chk("B_linePeriod", riseB[1] - riseB[0], 12);

    waitCyc(relB + 40);
    chk("B_preRstX", xB, 4);
    rstB = 0;
    @(negedge clk);
    chk("B_rst_sync", {hsB, vsB}, 2'b01);
    chk("B_rst_rgb", {rB, gB, bB}, 0);
    chk("B_rst_flags", {deB, ptB, fsB}, 0);
    chk("B_rst_xy", {xB, yB}, 0);
    rstB = 1; relB2 = cyc + 1;
    waitCyc(relB2);
    chk("B_restart", {fsB, deB, hsB, xB, yB}, {3'b110, 22'd0});
    chk("B_restart_rgb", {rB, gB, bB}, 12'h5A3);
    waitCyc(relB2 + 9);
    chk("B_restart_hsOn", hsB, 1);
    waitCyc(relB2 + 11);
    chk("B_restart_hsOff", hsB, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
